// File: rtl/obp_pkg.sv
// Shared widths, defaults and FSM state type for the processor host interface.
package obp_pkg;
    localparam int IN_W          = 2;
    localparam int OUT_W         = 7;
    localparam int CNT_W         = 8;
    localparam int CAP_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    // Wraps 255 -> 0 by construction.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return c + CNT_W'(1);
    endfunction
endpackage

// File: rtl/obp_host_if_if.sv
// Push/pop handshake between the host interface and its capture FIFO.
interface obp_cap_if
    import obp_pkg::*;
#(
    parameter int W = OUT_W
) ();
    logic         push;
    logic         pop;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         full;
    logic         empty;

    modport master (output push, pop, din, input dout, full, empty);
    modport slave  (input push, pop, din, output dout, full, empty);
endinterface

// File: rtl/obp_cap_fifo.sv
// Capture FIFO: a push into a full FIFO succeeds only if a pop frees a slot that same cycle.
module obp_cap_fifo
    import obp_pkg::*;
#(
    parameter int W     = OUT_W,
    parameter int DEPTH = CAP_DEPTH_DEF
) (
    input logic       clk,
    input logic       reset,
    obp_cap_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign bus.empty = (wr_ptr == rd_ptr);
    assign bus.full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign bus.dout  = mem[rd_ptr[AW-1:0]];

    assign do_pop  = bus.pop && !bus.empty;
    assign do_push = bus.push && (!bus.full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= bus.din;
    end
endmodule

// File: rtl/obp_host_if.sv
// Host-side control of a small processor: step/run/burst FSM, enabled-cycle
// counter, and change-triggered capture of the processor output.
module obp_host_if
    import obp_pkg::*;
#(
    parameter int CAP_DEPTH = CAP_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  host_in,
    input  logic             host_run,
    input  logic             host_step,
    input  logic [CNT_W-1:0] step_limit,
    output logic             proc_en,
    output logic [IN_W-1:0]  proc_in,
    input  logic [OUT_W-1:0] proc_out,
    output logic [OUT_W-1:0] cap_data,
    output logic             cap_valid,
    input  logic             cap_ready,
    output logic             cap_overflow,
    output logic             busy,
    output logic [CNT_W-1:0] step_count
);
    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [OUT_W-1:0] prev_out;

    obp_cap_if #(.W(OUT_W)) cap_bus ();

    obp_cap_fifo #(.W(OUT_W), .DEPTH(CAP_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .bus   (cap_bus)
    );

    assign proc_en = (state == ST_STEP) || (state == ST_RUN);
    assign busy    = (state != ST_IDLE);
    assign cnt_nxt = cnt_inc(step_count);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (host_run)       state_nxt = ST_RUN;
                else if (host_step) state_nxt = ST_STEP;
            end
            ST_STEP: state_nxt = ST_IDLE;
            ST_RUN: begin
                if (!host_run)                                      state_nxt = ST_IDLE;
                else if (step_limit != '0 && cnt_nxt == step_limit) state_nxt = ST_HALT;
            end
            ST_HALT: begin
                if (!host_run) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            step_count <= '0;
            proc_in    <= '0;
        end else begin
            state <= state_nxt;
            // A fresh run burst restarts the count; single steps keep accumulating.
            if (state == ST_IDLE && state_nxt == ST_RUN) step_count <= '0;
            else if (proc_en)                            step_count <= cnt_nxt;
            if (state_nxt == ST_STEP || state_nxt == ST_RUN) proc_in <= host_in;
        end
    end

    // Change detector: prev_out resets to 0, so a non-zero output right after reset is captured.
    assign cap_bus.push = (proc_out != prev_out);
    assign cap_bus.din  = proc_out;
    assign cap_bus.pop  = cap_ready && !cap_bus.empty;
    assign cap_data     = cap_bus.dout;
    assign cap_valid    = !cap_bus.empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_out     <= '0;
            cap_overflow <= 1'b0;
        end else begin
            prev_out <= proc_out;
            if (cap_bus.push && cap_bus.full && !cap_bus.pop) cap_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_obp_host_if.sv
// Directed + randomized bench for obp_host_if against a queue-based reference model.
module tb_obp_host_if;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] host_in;
    logic       host_run;
    logic       host_step;
    logic [7:0] step_limit;
    logic       proc_en;
    logic [1:0] proc_in;
    logic [6:0] proc_out;
    logic [6:0] cap_data;
    logic       cap_valid;
    logic       cap_ready;
    logic       cap_overflow;
    logic       busy;
    logic [7:0] step_count;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: mode 0=idle 1=step 2=run 3=halt
    int m_mode, m_cnt, m_in, m_prev;
    bit m_ovf;
    int q[$];

    obp_host_if #(.CAP_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .host_in      (host_in),
        .host_run     (host_run),
        .host_step    (host_step),
        .step_limit   (step_limit),
        .proc_en      (proc_en),
        .proc_in      (proc_in),
        .proc_out     (proc_out),
        .cap_data     (cap_data),
        .cap_valid    (cap_valid),
        .cap_ready    (cap_ready),
        .cap_overflow (cap_overflow),
        .busy         (busy),
        .step_count   (step_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_in = 0; m_prev = 0; m_ovf = 0;
        q.delete();
    endtask

    // Applies one rising edge to the model using the pre-edge inputs.
    task automatic model_edge();
        int  nm;
        bit  en, pop, push;
        en   = (m_mode == 1) || (m_mode == 2);
        pop  = cap_ready && (q.size() > 0);
        push = (int'(proc_out) != m_prev);
        nm   = m_mode;
        case (m_mode)
            0: nm = host_run ? 2 : (host_step ? 1 : 0);
            1: nm = 0;
            2: nm = !host_run ? 0 :
                    ((step_limit != 0 && ((m_cnt + 1) % 256) == int'(step_limit)) ? 3 : 2);
            default: nm = host_run ? 3 : 0;
        endcase
        if (m_mode == 0 && nm == 2) m_cnt = 0;
        else if (en)                m_cnt = (m_cnt + 1) % 256;
        if (nm == 1 || nm == 2) m_in = int'(host_in);
        if (pop) void'(q.pop_front());
        if (push) begin
            if (q.size() < DEPTH) q.push_back(int'(proc_out));
            else                  m_ovf = 1;
        end
        m_prev = int'(proc_out);
        m_mode = nm;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".proc_en"},   32'(proc_en),      32'(m_mode == 1 || m_mode == 2));
        chk({tag, ".proc_in"},   32'(proc_in),      m_in);
        chk({tag, ".step_cnt"},  32'(step_count),   m_cnt);
        chk({tag, ".busy"},      32'(busy),         32'(m_mode != 0));
        chk({tag, ".cap_valid"}, 32'(cap_valid),    32'(q.size() > 0));
        chk({tag, ".overflow"},  32'(cap_overflow), 32'(m_ovf));
        if (q.size() > 0) chk({tag, ".cap_data"}, 32'(cap_data), q[0]);
    endtask

    task automatic tick(input string tag = "tick");
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Assert reset between edges, check, release before the next edge.
    task automatic do_reset();
        #1 reset = 1'b0;
        #1 model_reset();
        check_all("reset");
        #1 reset = 1'b1;
    endtask

    initial begin
        int en_cnt;
        int last_cnt;
        bit saw_wrap;

        reset = 1'b0; host_in = '0; host_run = 0; host_step = 0;
        step_limit = '0; proc_out = '0; cap_ready = 0;
        model_reset();
        #2 check_all("por");
        #1 reset = 1'b1;

        // Single step
        host_in = 2'b10; host_step = 1;
        tick("step1");
        chk("step_en", 32'(proc_en), 1);
        chk("step_in", 32'(proc_in), 2);
        host_step = 0;
        tick("step2");
        chk("step_done_en", 32'(proc_en), 0);
        chk("step_count1", 32'(step_count), 1);
        chk("step_idle", 32'(busy), 0);

        // Bounded run burst
        step_limit = 8'd5; host_run = 1; host_in = 2'b01;
        en_cnt = 0;
        repeat (8) begin
            tick("burst");
            if (proc_en) en_cnt++;
        end
        chk("burst_len", en_cnt, 5);
        chk("halt_busy", 32'(busy), 1);
        host_run = 0;
        tick("halt_exit");
        chk("halt_idle", 32'(busy), 0);

        // Unlimited run with counter wrap
        step_limit = 8'd0; host_run = 1;
        saw_wrap = 0; last_cnt = int'(step_count);
        repeat (300) begin
            tick("freerun");
            if (step_count == 0 && last_cnt == 255) saw_wrap = 1;
            last_cnt = int'(step_count);
        end
        chk("wrap", 32'(saw_wrap), 1);
        host_run = 0;
        tick("freerun_stop");

        // Overflow with no pops, then ordered drain
        cap_ready = 0;
        for (int v = 1; v <= 5; v++) begin
            proc_out = 7'(v);
            tick("fill");
        end
        chk("ovf_set", 32'(cap_overflow), 1);
        cap_ready = 1;
        for (int e = 1; e <= 4; e++) begin
            chk("pop_order", 32'(cap_data), e);
            tick("drain");
        end
        chk("drained", 32'(cap_valid), 0);
        cap_ready = 0;

        // Full FIFO with simultaneous push and pop
        proc_out = '0;
        do_reset();
        for (int v = 1; v <= 4; v++) begin
            proc_out = 7'(v);
            tick("fill2");
        end
        proc_out = 7'd5; cap_ready = 1;
        tick("pushpop_full");
        chk("no_ovf", 32'(cap_overflow), 0);
        for (int e = 2; e <= 5; e++) begin
            chk("full_pp_order", 32'(cap_data), e);
            tick("drain2");
        end
        chk("drained2", 32'(cap_valid), 0);

        // Randomized traffic
        repeat (600) begin
            if ($urandom_range(0, 15) == 0) host_run = ~host_run;
            if ($urandom_range(0, 31) == 0) step_limit = 8'($urandom_range(0, 12));
            host_step = ($urandom_range(0, 3) == 0);
            host_in   = 2'($urandom);
            if ($urandom_range(0, 2) == 0) proc_out = 7'($urandom);
            cap_ready = 1'($urandom);
            tick("rand");
        end

        // Asynchronous reset mid-run with a non-empty FIFO
        host_step = 0; cap_ready = 0; proc_out = '0;
        do_reset();
        host_run = 1; step_limit = 8'd0;
        proc_out = 7'd3; tick("pre_arst");
        proc_out = 7'd9; tick("pre_arst");
        tick("pre_arst");
        chk("pre_arst_en", 32'(proc_en), 1);
        #2 reset = 1'b0;
        #1 chk("arst_en", 32'(proc_en), 0);
        chk("arst_valid", 32'(cap_valid), 0);
        model_reset();
        check_all("arst");
        host_run = 0; proc_out = 7'd7;
        #1 reset = 1'b1;
        tick("post_rst");
        chk("post_rst_cap", 32'(cap_valid), 1);
        chk("post_rst_data", 32'(cap_data), 7);
        tick("post_rst_hold");
        cap_ready = 1;
        tick("post_rst_pop");
        chk("post_rst_empty", 32'(cap_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
